// File: rtl/mic_sample_packer_pkg.sv
// Shared types and constants for the microphone sample packer.
package mic_pkt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } pkt_state_e;

   localparam int BYTES_PER_SAMPLE = 4;
   localparam int HEADER_BYTES     = 2;
   localparam int SEQ_W            = 16;

endpackage

// File: rtl/mic_sample_packer_sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy output.
// Pushes are assumed to be gated by the caller; pops on empty are ignored.
module sample_fifo #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_pop;

   always_comb begin
      do_pop   = rd_en_i && (level_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + LW'(wr_en_i) - LW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

endmodule

// File: rtl/mic_sample_packer.sv
// Buffers 32-bit mic samples and emits whole packets as big-endian bytes on AXI-Stream.
// Define MIC_PACKER_SEQ_HEADER_EN to prefix each packet with a 16-bit sequence number.
module mic_sample_packer
   import mic_pkt_pkg::*;
#(
   parameter int SAMPLES_PER_PKT = 64,
   parameter int FIFO_DEPTH      = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  mic_data,
   input  logic                         mic_data_valid,
   output logic [7:0]                   m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [15:0]                  overflow_count,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int SIDX_W = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;

   pkt_state_e        state_q, state_d;
   logic [1:0]        byte_q, byte_d;
   logic [SIDX_W-1:0] sidx_q, sidx_d;
   logic [15:0]       ovf_q, ovf_d;
   logic              wr_en;
   logic              pop;
   logic              hs;
   logic              last_smp;
   logic [31:0]       head;
`ifdef MIC_PACKER_SEQ_HEADER_EN
   logic [SEQ_W-1:0]  seq_q, seq_d;
`endif

   // Fullness uses the registered level, so a same-cycle pop cannot make room.
   assign wr_en = mic_data_valid && (fifo_level < LVL_W'(FIFO_DEPTH));

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (mic_data),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .level_o   (fifo_level)
   );

   always_comb begin
      ovf_d = ovf_q;
      if (mic_data_valid && !wr_en && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end
   end

   assign hs       = m_axis_tvalid && m_axis_tready;
   assign last_smp = (sidx_q == SIDX_W'(SAMPLES_PER_PKT - 1));

   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      sidx_d        = sidx_q;
      pop           = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tlast  = 1'b0;
`ifdef MIC_PACKER_SEQ_HEADER_EN
      seq_d         = seq_q;
`endif
      case (state_q)
         IDLE: begin
            if (fifo_level >= LVL_W'(SAMPLES_PER_PKT)) begin
               byte_d = 2'd0;
               sidx_d = '0;
`ifdef MIC_PACKER_SEQ_HEADER_EN
               state_d = HEADER;
`else
               state_d = PAYLOAD;
`endif
            end
         end
`ifdef MIC_PACKER_SEQ_HEADER_EN
         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = (byte_q == 2'd0) ? seq_q[15:8] : seq_q[7:0];
            if (hs) begin
               if (byte_q == 2'(HEADER_BYTES - 1)) begin
                  state_d = PAYLOAD;
                  byte_d  = 2'd0;
                  sidx_d  = '0;
               end else begin
                  byte_d = byte_q + 2'd1;
               end
            end
         end
`endif
         PAYLOAD: begin
            m_axis_tvalid = 1'b1;
            case (byte_q)
               2'd0:    m_axis_tdata = head[31:24];
               2'd1:    m_axis_tdata = head[23:16];
               2'd2:    m_axis_tdata = head[15:8];
               default: m_axis_tdata = head[7:0];
            endcase
            m_axis_tlast = (byte_q == 2'(BYTES_PER_SAMPLE - 1)) && last_smp;
            if (hs) begin
               if (byte_q == 2'(BYTES_PER_SAMPLE - 1)) begin
                  pop    = 1'b1;
                  byte_d = 2'd0;
                  if (last_smp) begin
                     state_d = IDLE;
`ifdef MIC_PACKER_SEQ_HEADER_EN
                     seq_d   = seq_q + 16'd1;
`endif
                  end else begin
                     sidx_d = sidx_q + SIDX_W'(1);
                  end
               end else begin
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         byte_q  <= 2'd0;
         sidx_q  <= '0;
         ovf_q   <= 16'd0;
`ifdef MIC_PACKER_SEQ_HEADER_EN
         seq_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         sidx_q  <= sidx_d;
         ovf_q   <= ovf_d;
`ifdef MIC_PACKER_SEQ_HEADER_EN
         seq_q   <= seq_d;
`endif
      end
   end

   assign overflow_count = ovf_q;

endmodule

// File: tb/tb_mic_sample_packer.sv
// Self-checking bench for mic_sample_packer (4 samples/packet, 8-deep FIFO).
module tb_mic_sample_packer;

   localparam int SPP   = 4;
   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic [31:0] mic_data;
   logic        mic_data_valid;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [15:0] overflow_count;
   logic [3:0]  fifo_level;

   mic_sample_packer #(
      .SAMPLES_PER_PKT (SPP),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mic_data       (mic_data),
      .mic_data_valid (mic_data_valid),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .overflow_count (overflow_count),
      .fifo_level     (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   typedef struct {
      logic [31:0] smp;
      logic [7:0]  b0, b1, b2, b3;
   } vec_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          acc_cnt = 0;
   logic [15:0] m_seq = 16'h0000;
   int          hs_cnt = 0;
   bit          rdy_mode = 1'b0;
   bit          stall_q = 1'b0;
   logic [7:0]  hold_d;
   logic        hold_l;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard push: header bytes open each packet, tlast closes it.
   task automatic push_exp(input logic [7:0] b0, b1, b2, b3);
      exp_t e;
`ifdef MIC_PACKER_SEQ_HEADER_EN
      if (acc_cnt == 0) begin
         e.d = m_seq[15:8]; e.l = 1'b0; exp_q.push_back(e);
         e.d = m_seq[7:0];  e.l = 1'b0; exp_q.push_back(e);
      end
`endif
      e.l = 1'b0;
      e.d = b0; exp_q.push_back(e);
      e.d = b1; exp_q.push_back(e);
      e.d = b2; exp_q.push_back(e);
      e.d = b3; e.l = (acc_cnt == SPP - 1); exp_q.push_back(e);
      acc_cnt++;
      if (acc_cnt == SPP) begin
         acc_cnt = 0;
         m_seq   = m_seq + 16'd1;
      end
   endtask

   task automatic wr(input logic [31:0] d);
      mic_data       = d;
      mic_data_valid = 1'b1;
      tick();
      mic_data_valid = 1'b0;
   endtask

   task automatic wr_push(input logic [31:0] d);
      wr(d);
      push_exp(d[31:24], d[23:16], d[15:8], d[7:0]);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (exp_q.size() == 0 && !m_axis_tvalid) break;
         tick();
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_tvalid", {31'd0, m_axis_tvalid}, 0);
   endtask

   // Output monitor: scoreboard pop on handshake, hold check while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_q) begin
            chk("hold_tvalid", {31'd0, m_axis_tvalid}, 1);
            chk("hold_tdata", {24'd0, m_axis_tdata}, {24'd0, hold_d});
            chk("hold_tlast", {31'd0, m_axis_tlast}, {31'd0, hold_l});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("tdata", {24'd0, m_axis_tdata}, {24'd0, e.d});
               chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e.l});
            end
         end
         stall_q = m_axis_tvalid && !m_axis_tready;
         hold_d  = m_axis_tdata;
         hold_l  = m_axis_tlast;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) m_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_tdata"}, {24'd0, m_axis_tdata}, 0);
      chk({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 0);
      chk({tag, "_tlast"}, {31'd0, m_axis_tlast}, 0);
      chk({tag, "_ovf"}, {16'd0, overflow_count}, 0);
      chk({tag, "_level"}, {28'd0, fifo_level}, 0);
   endtask

   initial begin
      vec_t tbl[8];
      int   base;
      tbl[0] = '{32'h1122_3344, 8'h11, 8'h22, 8'h33, 8'h44};
      tbl[1] = '{32'h5566_7788, 8'h55, 8'h66, 8'h77, 8'h88};
      tbl[2] = '{32'h99AA_BBCC, 8'h99, 8'hAA, 8'hBB, 8'hCC};
      tbl[3] = '{32'hDDEE_FF00, 8'hDD, 8'hEE, 8'hFF, 8'h00};
      tbl[4] = '{32'h0102_0304, 8'h01, 8'h02, 8'h03, 8'h04};
      tbl[5] = '{32'hA5A5_5A5A, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
      tbl[6] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[7] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};

      rst            = 1'b1;
      mic_data       = 32'd0;
      mic_data_valid = 1'b0;
      m_axis_tready  = 1'b1;
      tick();
      tick();
      chk_outputs_zero("reset");
      rst = 1'b0;
      tick();
      chk_outputs_zero("post_reset");

      // First packet: three samples must not start output.
      for (int i = 0; i < 3; i++) begin
         wr(tbl[i].smp);
         push_exp(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
      end
      repeat (6) tick();
      chk("partial_tvalid", {31'd0, m_axis_tvalid}, 0);
      chk("partial_level", {28'd0, fifo_level}, 3);
      wr(tbl[3].smp);
      push_exp(tbl[3].b0, tbl[3].b1, tbl[3].b2, tbl[3].b3);
      chk("start_idle_tvalid", {31'd0, m_axis_tvalid}, 0);
      tick();
      chk("start_tvalid", {31'd0, m_axis_tvalid}, 1);
      chk("start_tdata", {24'd0, m_axis_tdata}, {24'd0, exp_q[0].d});
      for (int i = 4; i < 8; i++) begin
         wr(tbl[i].smp);
         push_exp(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
      end
      wait_drain(200);

      // Random backpressure over 8 packets.
      rdy_mode = 1'b1;
      for (int p = 0; p < 8; p++) begin
         for (int k = 0; k < SPP; k++) begin
            wr_push($urandom);
            repeat (11) tick();
         end
      end
      wait_drain(2000);
      rdy_mode      = 1'b0;
      tick();
      m_axis_tready = 1'b1;
      tick();

      // Overflow: stalled output, 11 writes into an 8-deep FIFO.
      m_axis_tready = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i < DEPTH) wr_push(32'hC0DE_0000 + 32'(i));
         else wr(32'hBAD0_0000 + 32'(i));
      end
      tick();
      chk("ovf_level", {28'd0, fifo_level}, DEPTH);
      chk("ovf_count", {16'd0, overflow_count}, 3);
      repeat (5) tick();
      m_axis_tready = 1'b1;
      wait_drain(200);
      chk("ovf_drained_level", {28'd0, fifo_level}, 0);

      // Reset in the middle of a packet, then a fresh packet.
      base = hs_cnt;
      for (int i = 0; i < SPP; i++) wr_push(32'h7000_0000 + 32'(i));
      for (int i = 0; i < 100; i++) begin
         if (hs_cnt - base >= 5) break;
         tick();
      end
      chk("midpkt_bytes", hs_cnt - base, 5);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midpkt_reset");
      exp_q.delete();
      acc_cnt = 0;
      m_seq   = 16'h0000;
      tick();
      rst = 1'b0;
      tick();
      chk_outputs_zero("midpkt_after");
      for (int i = 0; i < SPP; i++) wr_push(32'h8000_0000 + 32'(i));
      wait_drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mic_sample_packer.md
# mic_sample_packer

Buffers 32-bit decimated microphone samples from the PDM/CIC front end and serialises them into fixed-size byte packets on an 8-bit AXI-Stream master for the Ethernet/UDP frame builder. The block sits directly downstream of the PDM microphone stage. It absorbs the stall-free sample stream in a FIFO and emits a packet only once a whole packet is buffered, so the output never underruns mid-packet.

## Interface
Parameters:
- SAMPLES_PER_PKT, 64: samples per packet; must be ≥1.
- FIFO_DEPTH, 256: sample FIFO depth; must be a power of two and ≥ SAMPLES_PER_PKT.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  reset; asynchronous, active-high.
- mic_data  input  32  sample from the CIC stage.
- mic_data_valid  input  1  one-cycle strobe qualifying mic_data; no backpressure.
- m_axis_tdata  output  8  packet byte.
- m_axis_tvalid  output  1  byte valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final byte of packet.
- overflow_count  output  16  number of dropped samples; saturates at 0xFFFF.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Write side: on mic_data_valid, the sample is written when fifo_level < FIFO_DEPTH.
  - Otherwise the sample is dropped and overflow_count increments (saturating).
  - Fullness is judged on the pre-cycle level. A pop in the same cycle does not rescue the write.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE: when fifo_level ≥ SAMPLES_PER_PKT, go to HEADER. Without MIC_PACKER_SEQ_HEADER_EN, go directly to PAYLOAD.
- HEADER: emits 2 bytes of seq_num, MSB first. After the second handshake, go to PAYLOAD.
- PAYLOAD: emits each sample as 4 bytes, big-endian (bits 31:24 first).
  - The FIFO pops when the 4th byte of a sample completes its handshake.
  - After the last byte of sample SAMPLES_PER_PKT completes its handshake, go to IDLE.
  - seq_num increments by 1, wrapping 0xFFFF→0x0000.
- Counters: byte index 0..3 and sample index 0..SAMPLES_PER_PKT-1. Both reset to 0 at entry to PAYLOAD.
- m_axis_tlast: 1 only on byte 3 of the last sample.
- AXI-Stream rules: once m_axis_tvalid is asserted, tdata, tlast and tvalid hold until tready. tvalid never drops without a handshake.
- Reset, asserted at any time including mid-packet:
  - FIFO empties; FSM goes to IDLE.
  - seq_num, overflow_count and all counters clear.
  - The partial packet is abandoned with no tlast.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, overflow_count=0, fifo_level=0.
- fifo_level updates the cycle after a write or pop.
- A simultaneous write and pop leaves the level unchanged.
- IDLE→HEADER happens the cycle after the level reaches the threshold. The first tvalid is asserted in the following cycle.
- Throughput: one byte per cycle while tready=1, with no bubbles between header and payload or between samples.
- Back-to-back packets: at least one IDLE cycle with tvalid=0 between the tlast handshake and the next packet's first byte.
- Packet length: 4·SAMPLES_PER_PKT+2 bytes with the header, 4·SAMPLES_PER_PKT bytes without.

## Configuration
- MIC_PACKER_SEQ_HEADER_EN, defined: the HEADER state and seq_num register exist, and every packet begins with the 16-bit sequence number.
- MIC_PACKER_SEQ_HEADER_EN, undefined: HEADER and seq_num are removed, IDLE goes directly to PAYLOAD, and packets carry samples only.

## Structure
- Package mic_pkt_pkg contains:
  - the state enum (IDLE/HEADER/PAYLOAD);
  - BYTES_PER_SAMPLE=4;
  - HEADER_BYTES=2;
  - the seq_num width of 16.
- Sub-module sample_fifo: synchronous first-word-fall-through FIFO, 32 bits wide and FIFO_DEPTH deep, with a level output. The top level contains the write-gating logic, FSM, counters and byte mux.

## Test plan
- SAMPLES_PER_PKT=4, header on; write 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 with tready=1 → bytes 00 00 11 22 33 44 … FF 00 (18 bytes), tlast on byte 18 only, then a second packet with header 00 01.
- Random tready toggling (50%) over 8 packets → byte stream identical to the tready=1 case; tdata/tlast stable whenever tvalid=1 and tready=0.
- FIFO_DEPTH=8, tready=0, write 11 samples → fifo_level=8, overflow_count=3; release tready → the first 8 samples emerge in order.
- Assert rst mid-PAYLOAD (byte 5) → all outputs 0 the next cycle; after release, the next packet has header 00 00.
- 65536 packets → seq_num wraps from FF FF to 00 00; header-off build → 16-byte packets with no sequence bytes.
- Write 3 of 4 samples and hold → tvalid stays 0; the 4th write starts the packet.
